// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pkg: shared types and constants for the IF-stage PC generator.
// Holds the branch-kind and fetch-state encodings plus the sequential PC step.
package fetch_pkg;

   typedef enum logic [1:0] {
      BR_COND   = 2'd0,
      BR_UNCOND = 2'd1,
      BR_REG    = 2'd2,
      BR_RSVD   = 2'd3
   } br_kind_e;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam int unsigned PC_STEP = 4;

endpackage : fetch_pkg

// File: rtl/fetch_pc_gen_branch_target_calc.sv
// branch_target_calc: combinational branch target generation.
// Sign-extends the word-offset immediates, scales them to bytes and adds the
// branch PC; the register form passes reg_target straight through.
module branch_target_calc
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = 64,
   parameter int COND_W   = 19,
   parameter int UNCOND_W = 26
) (
   input  logic [1:0]        br_kind,
   input  logic [ADDR_W-1:0] br_base_pc,
   input  logic [COND_W-1:0] cond_imm,
   input  logic [UNCOND_W-1:0] uncond_imm,
   input  logic [ADDR_W-1:0] reg_target,
   output logic [ADDR_W-1:0] target
);

   logic signed [ADDR_W-1:0] cond_ext;
   logic signed [ADDR_W-1:0] uncond_ext;
   logic signed [ADDR_W-1:0] cond_off;
   logic signed [ADDR_W-1:0] uncond_off;
   logic        [ADDR_W-1:0] cond_tgt;
   logic        [ADDR_W-1:0] uncond_tgt;

   // Word offsets become byte offsets; the add wraps modulo 2^ADDR_W
   always_comb begin
      cond_ext   = {{(ADDR_W-COND_W){cond_imm[COND_W-1]}}, cond_imm};
      uncond_ext = {{(ADDR_W-UNCOND_W){uncond_imm[UNCOND_W-1]}}, uncond_imm};
      cond_off   = cond_ext <<< 2;
      uncond_off = uncond_ext <<< 2;
      cond_tgt   = br_base_pc + $unsigned(cond_off);
      uncond_tgt = br_base_pc + $unsigned(uncond_off);
   end

   // Select the target for the resolved branch kind; reserved kinds are never
   // taken, so their value is irrelevant and the branch PC is returned
   always_comb begin
      target = br_base_pc;
      case (br_kind_e'(br_kind))
         BR_COND:   target = cond_tgt;
         BR_UNCOND: target = uncond_tgt;
         BR_REG:    target = reg_target;
         default:   target = br_base_pc;
      endcase
   end

endmodule : branch_target_calc

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: IF-stage program counter and next-PC generator.
// Holds the fetch PC, redirects on taken branches (overriding stall and HALT),
// runs the INIT/RUN/HALT fetch state machine and counts taken branches.
// Optional feature macro: PC_ALIGN_CHECK_EN (forces taken targets to word
// alignment and raises a sticky align_err; when undefined align_err is 0).
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter int              ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              COND_W   = 19,
   parameter int              UNCOND_W = 26,
   parameter int              CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                halt_req,
   input  logic                br_valid,
   input  logic [1:0]          br_kind,
   input  logic                br_cond_true,
   input  logic [ADDR_W-1:0]   br_base_pc,
   input  logic [COND_W-1:0]   cond_imm,
   input  logic [UNCOND_W-1:0] uncond_imm,
   input  logic [ADDR_W-1:0]   reg_target,
   output logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W-1:0]   pc_plus4,
   output logic [ADDR_W-1:0]   link_addr,
   output logic                fetch_valid,
   output logic                flush,
   output logic [CNT_W-1:0]    taken_cnt,
   output logic                align_err
);

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] target_ld;
   logic              taken;

   branch_target_calc #(
      .ADDR_W   (ADDR_W),
      .COND_W   (COND_W),
      .UNCOND_W (UNCOND_W)
   ) u_target (
      .br_kind    (br_kind),
      .br_base_pc (br_base_pc),
      .cond_imm   (cond_imm),
      .uncond_imm (uncond_imm),
      .reg_target (reg_target),
      .target     (br_target)
   );

   // Branch resolution: reserved kind and false conditions are not taken
   always_comb begin
      taken = 1'b0;
      if (br_valid) begin
         case (br_kind_e'(br_kind))
            BR_COND:   taken = br_cond_true;
            BR_UNCOND: taken = 1'b1;
            BR_REG:    taken = 1'b1;
            default:   taken = 1'b0;
         endcase
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic align_err_q, align_err_d;

   assign target_ld = {br_target[ADDR_W-1:2], 2'b00};

   // Sticky flag: any taken target with non-zero low bits sets it until reset
   always_comb begin
      align_err_d = align_err_q | (taken & (|br_target[1:0]));
   end

   // Alignment flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) align_err_q <= 1'b0;
      else     align_err_q <= align_err_d;
   end

   assign align_err = align_err_q;
`else
   assign target_ld = br_target;
   assign align_err = 1'b0;
`endif

   // Sequential and link addresses wrap modulo 2^ADDR_W
   always_comb begin
      pc_plus4  = pc_q + ADDR_W'(PC_STEP);
      link_addr = br_base_pc + ADDR_W'(PC_STEP);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= INIT;
      else     state_q <= state_d;
   end

   // FSM next state: a taken branch leaves RUN/HALT unchanged, so a halt
   // request coinciding with a redirect is honoured one cycle later
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    state_d = RUN;
         RUN:     if (halt_req && !taken) state_d = HALT;
         HALT:    if (!halt_req && !taken) state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   // FSM outputs: only RUN with no stall or redirect fetches a real instruction
   always_comb begin
      fetch_valid = (state_q == RUN) && !stall && !taken;
      flush       = taken;
   end

   // Next PC: redirect beats stall/halt, which beat sequential advance
   always_comb begin
      pc_d = pc_q;
      if (taken)                          pc_d = target_ld;
      else if (stall || state_q != RUN)   pc_d = pc_q;
      else                                pc_d = pc_plus4;
   end

   // Saturating taken-branch counter
   always_comb begin
      taken_cnt_d = taken_cnt_q;
      if (taken && !(&taken_cnt_q)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
   end

   // PC and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         taken_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign pc        = pc_q;
   assign taken_cnt = taken_cnt_q;

endmodule : fetch_pc_gen
